// File: rtl/i2c_controller.sv
// I2C read-only slave control FSM: address phase, ACK/NACK,
// byte transmit, master-ACK sampling and repeated start.
module i2c_controller (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       byte_received,
  input  logic       ack_prep,
  input  logic       check_ack,
  input  logic       ack_done,
  input  logic       rw_mode,
  input  logic       address_match,
  input  logic       sda_in,
  input  logic       tx_fifo_empty,
  output logic       rx_enable,
  output logic       tx_enable,
  output logic       read_enable,
  output logic       load_data,
  output logic [1:0] sda_mode
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ACK_WAIT,
    ACK_DRIVE,
    NACK_WAIT,
    NACK_DRIVE,
    LOAD,
    TX,
    MACK,
    WAIT_STOP
  } state_t;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_ACK  = 2'b01;
  localparam logic [1:0] MODE_NACK = 2'b10;
  localparam logic [1:0] MODE_TX   = 2'b11;

  state_t state;
  state_t state_nxt;
  logic   mack;
  logic   addr_ok;

  assign addr_ok = address_match & rw_mode & ~tx_fifo_empty;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_found)
          state_nxt = ADDR;
      end
      ADDR: begin
        if (byte_received)
          state_nxt = addr_ok ? ACK_WAIT : NACK_WAIT;
      end
      ACK_WAIT: begin
        if (ack_prep)
          state_nxt = ACK_DRIVE;
      end
      ACK_DRIVE: begin
        if (ack_done)
          state_nxt = LOAD;
      end
      NACK_WAIT: begin
        if (ack_prep)
          state_nxt = NACK_DRIVE;
      end
      NACK_DRIVE: begin
        if (ack_done)
          state_nxt = WAIT_STOP;
      end
      LOAD: state_nxt = TX;
      TX: begin
        if (ack_prep)
          state_nxt = MACK;
      end
      MACK: begin
        // underflow leaves SDA released: master reads 0xFF
        if (ack_done)
          state_nxt = (!mack && !tx_fifo_empty)
                    ? LOAD : WAIT_STOP;
      end
      WAIT_STOP: begin
        if (stop_found)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // bus conditions override; START beats STOP
    if (stop_found)
      state_nxt = IDLE;
    if (start_found)
      state_nxt = ADDR;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= IDLE;
      mack        <= 1'b1;
      rx_enable   <= 1'b0;
      tx_enable   <= 1'b0;
      read_enable <= 1'b0;
      load_data   <= 1'b0;
      sda_mode    <= MODE_IDLE;
    end else begin
      state       <= state_nxt;
      rx_enable   <= (state_nxt == ADDR);
      tx_enable   <= (state_nxt == TX);
      read_enable <= (state_nxt == LOAD);
      load_data   <= (state_nxt == LOAD);
      unique case (state_nxt)
        ACK_DRIVE:  sda_mode <= MODE_ACK;
        NACK_DRIVE: sda_mode <= MODE_NACK;
        TX:         sda_mode <= MODE_TX;
        default:    sda_mode <= MODE_IDLE;
      endcase
      if (state_nxt == LOAD)
        mack <= 1'b1;
      else if (state == MACK && check_ack)
        mack <= sda_in;
    end
  end

endmodule

// File: tb/tb_i2c_controller.sv
// Bench for i2c_controller: scripted vector table followed by
// random bus events checked against a transaction-level model.
module tb_i2c_controller;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start_found, stop_found, byte_received;
  logic       ack_prep, check_ack, ack_done;
  logic       rw_mode, address_match, sda_in, tx_fifo_empty;
  logic       rx_enable, tx_enable, read_enable, load_data;
  logic [1:0] sda_mode;

  i2c_controller dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .start_found   (start_found),
    .stop_found    (stop_found),
    .byte_received (byte_received),
    .ack_prep      (ack_prep),
    .check_ack     (check_ack),
    .ack_done      (ack_done),
    .rw_mode       (rw_mode),
    .address_match (address_match),
    .sda_in        (sda_in),
    .tx_fifo_empty (tx_fifo_empty),
    .rx_enable     (rx_enable),
    .tx_enable     (tx_enable),
    .read_enable   (read_enable),
    .load_data     (load_data),
    .sda_mode      (sda_mode)
  );

  always #5 clk = ~clk;

  localparam logic [10:0] NR = 11'h400;
  localparam logic [10:0] ST = 11'h200;
  localparam logic [10:0] SP = 11'h100;
  localparam logic [10:0] BR = 11'h080;
  localparam logic [10:0] PR = 11'h040;
  localparam logic [10:0] CK = 11'h020;
  localparam logic [10:0] DN = 11'h010;
  localparam logic [10:0] RW = 11'h008;
  localparam logic [10:0] AM = 11'h004;
  localparam logic [10:0] SD = 11'h002;
  localparam logic [10:0] EM = 11'h001;

  localparam logic [5:0] Z   = 6'h00;
  localparam logic [5:0] RXO = 6'h20;
  localparam logic [5:0] ACK = 6'h01;
  localparam logic [5:0] NAK = 6'h02;
  localparam logic [5:0] LDO = 6'h0C;
  localparam logic [5:0] TXO = 6'h13;

  typedef struct {
    string       name;
    logic [10:0] in;
    logic [5:0]  exp;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  // transaction-level reference: where in the I2C read
  // transaction the slave currently is
  typedef enum {
    B_IDLE, B_ADDR, B_ACKW, B_ACKD, B_NAKW,
    B_NAKD, B_LOAD, B_SEND, B_MACK, B_HOLD
  } phase_t;

  phase_t ph = B_IDLE;
  bit     master_nack = 1'b1;

  function automatic logic [5:0] model_out(phase_t p);
    case (p)
      B_ADDR:  return RXO;
      B_ACKD:  return ACK;
      B_NAKD:  return NAK;
      B_LOAD:  return LDO;
      B_SEND:  return TXO;
      default: return Z;
    endcase
  endfunction

  task automatic model_step(logic [10:0] v);
    phase_t n;
    n = ph;
    if (!v[10]) begin
      ph = B_IDLE;
      master_nack = 1'b1;
      return;
    end
    case (ph)
      B_IDLE: ;
      B_ADDR:
        if (v[7])
          n = (v[2] && v[3] && !v[0]) ? B_ACKW : B_NAKW;
      B_ACKW: if (v[6]) n = B_ACKD;
      B_ACKD: if (v[4]) n = B_LOAD;
      B_NAKW: if (v[6]) n = B_NAKD;
      B_NAKD: if (v[4]) n = B_HOLD;
      B_LOAD: n = B_SEND;
      B_SEND: if (v[6]) n = B_MACK;
      B_MACK:
        if (v[4])
          n = (!master_nack && !v[0]) ? B_LOAD : B_HOLD;
      default: ;
    endcase
    if (v[8]) n = B_IDLE;
    if (v[9]) n = B_ADDR;
    if (n == B_LOAD)
      master_nack = 1'b1;
    else if (ph == B_MACK && v[5])
      master_nack = v[1];
    ph = n;
  endtask

  task automatic drive(logic [10:0] v);
    n_rst         = v[10];
    start_found   = v[9];
    stop_found    = v[8];
    byte_received = v[7];
    ack_prep      = v[6];
    check_ack     = v[5];
    ack_done      = v[4];
    rw_mode       = v[3];
    address_match = v[2];
    sda_in        = v[1];
    tx_fifo_empty = v[0];
  endtask

  task automatic cycle(logic [10:0] v);
    drive(v);
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  task automatic check(string name, logic [5:0] exp);
    logic [5:0] act;
    act = {rx_enable, tx_enable, read_enable, load_data, sda_mode};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %06b want %06b", name, act, exp);
    end
  endtask

  task automatic add(string n, logic [10:0] i, logic [5:0] e);
    vec_t t;
    t.name = n;
    t.in   = i;
    t.exp  = e;
    tbl.push_back(t);
  endtask

  localparam logic [10:0] RD = NR | BR | AM | RW;

  initial begin
    drive(11'h000);
    add("reset",          11'h000,     Z);
    add("idle_quiet",     NR,          Z);
    add("idle_ign_br",    RD,          Z);
    add("start",          NR | ST,     RXO);
    add("addr_hold",      NR,          RXO);
    add("addr_match",     RD,          Z);
    add("ackw_hold",      NR,          Z);
    add("ack_prep",       NR | PR,     ACK);
    add("ack_hold",       NR,          ACK);
    add("ack_done_load",  NR | DN,     LDO);
    add("tx1",            NR,          TXO);
    add("tx_ign_br",      NR | BR,     TXO);
    add("tx_prep_mack",   NR | PR,     Z);
    add("mack_chk0",      NR | CK,     Z);
    add("mack_load2",     NR | DN,     LDO);
    add("tx2",            NR,          TXO);
    add("tx2_prep",       NR | PR,     Z);
    add("mack_chk1",      NR | CK | SD, Z);
    add("nack_hold",      NR | DN,     Z);
    add("hold_stop",      NR | SP,     Z);
    add("uf_start",       NR | ST,     RXO);
    add("uf_addr",        RD,          Z);
    add("uf_prep",        NR | PR,     ACK);
    add("uf_done",        NR | DN,     LDO);
    add("uf_tx",          NR,          TXO);
    add("uf_prep2",       NR | PR,     Z);
    add("uf_chk0",        NR | CK,     Z);
    add("uf_empty",       NR | DN | EM, Z);
    add("uf_hold",        NR,          Z);
    add("nock_start",     NR | ST,     RXO);
    add("nock_addr",      RD,          Z);
    add("nock_prep",      NR | PR,     ACK);
    add("nock_done",      NR | DN,     LDO);
    add("nock_tx",        NR,          TXO);
    add("nock_prep2",     NR | PR,     Z);
    add("nock_done2",     NR | DN,     Z);
    add("mm_start",       NR | ST,     RXO);
    add("mm_addr",        NR | BR | RW, Z);
    add("mm_prep",        NR | PR,     NAK);
    add("mm_hold",        NR,          NAK);
    add("mm_done",        NR | DN,     Z);
    add("mm_ign_br",      NR | BR,     Z);
    add("mm_stop",        NR | SP,     Z);
    add("wr_start",       NR | ST,     RXO);
    add("wr_addr",        NR | BR | AM, Z);
    add("wr_prep",        NR | PR,     NAK);
    add("wr_done",        NR | DN,     Z);
    add("em_start",       NR | ST,     RXO);
    add("em_addr",        RD | EM,     Z);
    add("em_prep",        NR | PR,     NAK);
    add("em_done",        NR | DN,     Z);
    add("rs_start",       NR | ST,     RXO);
    add("rs_addr",        RD,          Z);
    add("rs_prep",        NR | PR,     ACK);
    add("rs_done",        NR | DN,     LDO);
    add("rs_tx",          NR,          TXO);
    add("rs_restart",     NR | ST,     RXO);
    add("sp_addr",        RD,          Z);
    add("sp_prep",        NR | PR,     ACK);
    add("sp_stop_ack",    NR | SP,     Z);
    add("sp_idle_prep",   NR | PR,     Z);
    add("both_pulses",    NR | ST | SP, RXO);
    add("rt_addr",        RD,          Z);
    add("rt_prep",        NR | PR,     ACK);
    add("rt_done",        NR | DN,     LDO);
    add("rt_tx",          NR,          TXO);
    add("rt_reset",       11'h000,     Z);
    add("rt_idle",        NR,          Z);
    add("rt_idle_br",     RD,          Z);
    add("rt_start",       NR | ST,     RXO);

    foreach (tbl[i]) begin
      cycle(tbl[i].in);
      check(tbl[i].name, tbl[i].exp);
    end

    cycle(11'h000);
    check("rand_reset", model_out(ph));
    for (int k = 0; k < 3000; k++) begin
      logic [10:0] v;
      int r;
      v = NR;
      r = $urandom_range(0, 99);
      if      (r < 4)  v |= ST;
      else if (r < 7)  v |= SP;
      else if (r < 25) v |= BR;
      else if (r < 45) v |= PR;
      else if (r < 60) v |= CK;
      else if (r < 80) v |= DN;
      else if (r == 99) v |= ST | SP;
      if ($urandom_range(0, 4) != 0) v |= RW;
      if ($urandom_range(0, 4) != 0) v |= AM;
      if ($urandom_range(0, 1) != 0) v |= SD;
      if ($urandom_range(0, 6) == 0) v |= EM;
      if ($urandom_range(0, 299) == 0) v &= ~NR;
      cycle(v);
      check("rand", model_out(ph));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
